// File: rtl/mem_data_reg_ctl.sv
// rtl/mem_data_reg_ctl.sv - load data register with wait states, lane extraction and error flags
//
// Captures memory read data for a load after a variable number of wait
// cycles, extracts the addressed byte/half/word/dword lane and zero- or
// sign-extends it to DATA_W. The result is held until the next load.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req        load request pulse from the control unit
//   size       access size, (1<<size) bytes
//   sign_ext   1 = sign-extend the lane, 0 = zero-extend
//   addr_lo    low address bits selecting the byte lane
//   mem_rdata  raw memory read data
//   mem_ready  memory read data valid this cycle
//   flush      abort an in-flight load
//   out        extended load result
//   valid      out holds a completed load result
//   busy       waiting for memory
//   err        sticky error flag, cleared by the next accepted req
//   err_code   00 none, 01 misaligned, 10 timeout, 11 size too large

module mem_data_reg_ctl #(
    parameter int DATA_W  = 32,
    parameter int LANE_W  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [LANE_W-1:0] addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

    localparam logic [31:0] DATA_BITS = 32'(DATA_W);
    localparam logic [7:0]  LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [LANE_W-1:0] addr_q;

    // Request checks act on the live request attributes.
    logic [31:0]       req_bits;
    logic              too_big;
    logic [LANE_W-1:0] align_mask;
    logic              misaligned;

    assign req_bits   = 32'd8 << size;
    assign too_big    = req_bits > DATA_BITS;
    assign align_mask = ~({LANE_W{1'b1}} << size);
    assign misaligned = (addr_lo & align_mask) != '0;

    // Extraction acts on the latched attributes. A full-width lane yields an
    // all-ones lane_mask, so the fill term vanishes and data passes through.
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] msb_mask;
    logic [DATA_W-1:0] extracted;
    logic [6:0]        lane_bits;
    logic              lane_msb;

    assign shifted   = mem_rdata >> {addr_q, 3'b000};
    assign lane_bits = 7'd8 << size_q;
    assign lane_mask = ~({DATA_W{1'b1}} << lane_bits);
    assign msb_mask  = {{(DATA_W-1){1'b0}}, 1'b1} << (lane_bits - 7'd1);
    assign lane_msb  = |(shifted & msb_mask);
    assign extracted = (shifted & lane_mask) | ((sign_q & lane_msb) ? ~lane_mask : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            out      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            wait_cnt <= '0;
            size_q   <= '0;
            sign_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE, FULL: begin
                    // flush is deliberately ignored here; it only aborts WAIT.
                    if (req) begin
                        size_q   <= size;
                        sign_q   <= sign_ext;
                        addr_q   <= addr_lo;
                        valid    <= 1'b0;
                        wait_cnt <= '0;
                        if (too_big) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end else if (misaligned) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            state    <= WAIT;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            err_code <= 2'b00;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (mem_ready) begin
                        out   <= extracted;
                        valid <= 1'b1;
                        state <= FULL;
                        busy  <= 1'b0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_data_reg_ctl.sv
// tb/tb_mem_data_reg_ctl.sv - self-checking bench for mem_data_reg_ctl (32-bit and 64-bit instances)
module tb_mem_data_reg_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 32-bit instance, TIMEOUT=15
    logic        a_req, a_sign, a_ready, a_flush;
    logic [1:0]  a_size, a_addr;
    logic [31:0] a_rdata, a_out;
    logic        a_valid, a_busy, a_err;
    logic [1:0]  a_code;

    // 64-bit instance, TIMEOUT=1
    logic        b_req, b_sign, b_ready, b_flush;
    logic [1:0]  b_size;
    logic [2:0]  b_addr;
    logic [63:0] b_rdata, b_out;
    logic        b_valid, b_busy, b_err;
    logic [1:0]  b_code;

    mem_data_reg_ctl #(.DATA_W(32), .LANE_W(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(a_req), .size(a_size), .sign_ext(a_sign),
        .addr_lo(a_addr), .mem_rdata(a_rdata), .mem_ready(a_ready), .flush(a_flush),
        .out(a_out), .valid(a_valid), .busy(a_busy), .err(a_err), .err_code(a_code)
    );

    mem_data_reg_ctl #(.DATA_W(64), .LANE_W(3), .TIMEOUT(1)) dut64 (
        .clk(clk), .rst(rst), .req(b_req), .size(b_size), .sign_ext(b_sign),
        .addr_lo(b_addr), .mem_rdata(b_rdata), .mem_ready(b_ready), .flush(b_flush),
        .out(b_out), .valid(b_valid), .busy(b_busy), .err(b_err), .err_code(b_code)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state per instance (0 = 32-bit, 1 = 64-bit)
    logic [63:0] e_out   [2];
    bit          e_valid [2];
    bit          e_err   [2];
    logic [1:0]  e_code  [2];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(bit b, string tag, bit e_busy);
        if (!b) begin
            chk({tag, ".out"},   {32'h0, a_out},   e_out[0]);
            chk({tag, ".valid"}, 64'(a_valid),     64'(e_valid[0]));
            chk({tag, ".busy"},  64'(a_busy),      64'(e_busy));
            chk({tag, ".err"},   64'(a_err),       64'(e_err[0]));
            chk({tag, ".code"},  64'(a_code),      64'(e_code[0]));
        end else begin
            chk({tag, ".out64"},   b_out,          e_out[1]);
            chk({tag, ".valid64"}, 64'(b_valid),   64'(e_valid[1]));
            chk({tag, ".busy64"},  64'(b_busy),    64'(e_busy));
            chk({tag, ".err64"},   64'(b_err),     64'(e_err[1]));
            chk({tag, ".code64"},  64'(b_code),    64'(e_code[1]));
        end
    endtask

    // Lane of (8<<size) bits at byte addr, extended, truncated to dw bits.
    function automatic logic [63:0] ref_ext(int dw, logic [63:0] data, int size, int addr, bit sgn);
        int          nb;
        logic [63:0] lane;
        logic [63:0] m;
        nb   = 8 << size;
        lane = data >> (addr * 8);
        if (nb < 64) begin
            m    = (64'd1 << nb) - 64'd1;
            lane = lane & m;
            if (sgn && ((lane >> (nb - 1)) & 64'd1) == 64'd1) lane = lane | ~m;
        end
        if (dw == 32) lane = lane & 64'hFFFF_FFFF;
        return lane;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(bit b, bit rq, int sz, bit sg, int ad, logic [63:0] d, bit rdy, bit fl);
        if (!b) begin
            a_req = rq; a_size = 2'(sz); a_sign = sg; a_addr = 2'(ad);
            a_rdata = d[31:0]; a_ready = rdy; a_flush = fl;
        end else begin
            b_req = rq; b_size = 2'(sz); b_sign = sg; b_addr = 3'(ad);
            b_rdata = d; b_ready = rdy; b_flush = fl;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One load: accept, 'delay' WAIT cycles without ready, then ready (or flush+ready).
    task automatic load(bit b, int size, bit sgn, int addr, logic [63:0] data, int delay, bit do_flush);
        int dw;
        dw = b ? 64 : 32;
        if (!b) data = data & 64'hFFFF_FFFF;
        // ready/flush in the request cycle must be ignored
        drive(b, 1'b1, size, sgn, addr, rnd64(), 1'($urandom), 1'($urandom));
        step();
        drive(b, 1'b0, $urandom % 4, 1'($urandom), $urandom % 8, rnd64(), 1'b0, 1'b0);
        e_valid[b] = 0; e_err[b] = 0; e_code[b] = 2'b00;
        if ((8 << size) > dw) begin
            e_err[b] = 1; e_code[b] = 2'b11;
            check_all(b, "reject_size", 1'b0);
            return;
        end
        if ((addr % (1 << size)) != 0) begin
            e_err[b] = 1; e_code[b] = 2'b01;
            check_all(b, "reject_align", 1'b0);
            return;
        end
        check_all(b, "accept", 1'b1);
        for (int i = 0; i < delay; i++) begin
            drive(b, 1'b0, $urandom % 4, 1'($urandom), $urandom % 8, rnd64(), 1'b0, 1'b0);
            step();
            check_all(b, "wait", 1'b1);
        end
        drive(b, 1'b0, $urandom % 4, 1'($urandom), $urandom % 8, data, 1'b1, do_flush);
        step();
        drive(b, 1'b0, 0, 1'b0, 0, rnd64(), 1'b0, 1'b0);
        if (!do_flush) begin
            e_out[b]   = ref_ext(dw, data, size, addr, sgn);
            e_valid[b] = 1;
        end
        check_all(b, do_flush ? "flush" : "capture", 1'b0);
    endtask

    // Idle/FULL cycles with noise on the ignored inputs; outputs must hold.
    task automatic hold(bit b, int n);
        for (int i = 0; i < n; i++) begin
            drive(b, 1'b0, $urandom % 4, 1'($urandom), $urandom % 8, rnd64(), 1'($urandom), 1'($urandom));
            step();
            check_all(b, "hold", 1'b0);
        end
    endtask

    // busy must stay high for exactly tmo cycles, then timeout error.
    task automatic timeout_test(bit b, int tmo);
        drive(b, 1'b1, 2, 1'b0, 0, rnd64(), 1'b0, 1'b0);
        step();
        e_valid[b] = 0; e_err[b] = 0; e_code[b] = 2'b00;
        for (int i = 0; i < tmo; i++) begin
            drive(b, 1'b0, 0, 1'b0, 0, rnd64(), 1'b0, 1'b0);
            check_all(b, "tmo_busy", 1'b1);
            step();
        end
        e_err[b] = 1; e_code[b] = 2'b10;
        check_all(b, "tmo_abort", 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            e_out[k] = '0; e_valid[k] = 0; e_err[k] = 0; e_code[k] = 2'b00;
        end
        drive(0, 1'b0, 0, 1'b0, 0, 64'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 0, 1'b0, 0, 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        check_all(0, "reset", 1'b0);
        check_all(1, "reset", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Word load, ready three cycles after the request, then a long hold
        load(0, 2, 1'b0, 0, 64'hDEADBEEF, 2, 1'b0);
        hold(0, 10);

        // Byte extension
        load(0, 0, 1'b1, 2, 64'h12F45678, 0, 1'b0);
        load(0, 0, 1'b0, 2, 64'h12F45678, 1, 1'b0);

        // Half load, then a misaligned half
        load(0, 1, 1'b1, 2, 64'h8001ABCD, 0, 1'b0);
        load(0, 1, 1'b1, 1, 64'h8001ABCD, 0, 1'b0);
        hold(0, 2);

        // dword on a 32-bit path is rejected
        load(0, 3, 1'b0, 0, 64'h1, 0, 1'b0);

        // Timeout then a fresh request clears the error
        timeout_test(0, 15);
        load(0, 2, 1'b1, 0, 64'h7654_3210, 3, 1'b0);

        // Flush together with ready: no capture, out unchanged
        load(0, 2, 1'b0, 0, 64'hCAFEF00D, 1, 1'b1);
        hold(0, 2);

        // Asynchronous reset in the middle of WAIT
        drive(0, 1'b1, 2, 1'b0, 0, rnd64(), 1'b0, 1'b0);
        step();
        drive(0, 1'b0, 0, 1'b0, 0, rnd64(), 1'b0, 1'b0);
        check_all(0, "pre_rst_wait", 1'b1);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            e_out[k] = '0; e_valid[k] = 0; e_err[k] = 0; e_code[k] = 2'b00;
        end
        check_all(0, "async_rst", 1'b0);
        check_all(1, "async_rst", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_all(0, "post_rst", 1'b0);

        // 64-bit instance: full width and word lane, TIMEOUT=1
        load(1, 3, 1'b0, 0, 64'h0123456789ABCDEF, 0, 1'b0);
        load(1, 2, 1'b1, 4, 64'h0123456789ABCDEF, 0, 1'b0);
        load(1, 2, 1'b1, 4, 64'h89AB_CDEF_0000_0000, 0, 1'b0);
        timeout_test(1, 1);
        load(1, 3, 1'b0, 4, 64'h0, 0, 1'b0);

        // Randomized loads on both instances
        for (int n = 0; n < 40; n++) begin
            bit b;
            int sz, ad, dly;
            b  = 1'($urandom);
            sz = $urandom % 4;
            ad = b ? ($urandom % 8) : ($urandom % 4);
            if ($urandom % 4 != 0) ad = ad & ~((1 << sz) - 1);
            dly = b ? 0 : ($urandom % 6);
            load(b, sz, 1'($urandom), ad, rnd64(), dly, ($urandom % 8) == 0);
            hold(b, $urandom % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_data_reg_ctl.md
Name: mem_data_reg_ctl

Overview:
Parametrised successor to the multicycle CPU's memory data register. It captures read data from data memory across a variable number of wait-state cycles, then extracts the addressed byte, halfword or word and zero- or sign-extends it. The result is held stable for the writeback stage until the next load. It sits between the data memory read port and the register-file write mux. It also flags misaligned accesses and memory time-outs to the control unit.

Parameters:
DATA_W, 32, data path width in bits; power of two, >= 32.
LANE_W, 2, width of addr_lo; equals log2(DATA_W/8).
TIMEOUT, 15, maximum wait cycles in WAIT before aborting; range 1..255.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
req  in  1  load request from control unit; 1-cycle pulse
size  in  2  access size; access width = (1<<size) bytes: 00 byte, 01 half, 10 word, 11 dword
sign_ext  in  1  1 = sign-extend, 0 = zero-extend
addr_lo  in  LANE_W  low address bits; select the byte lane
mem_rdata  in  DATA_W  raw read data from memory
mem_ready  in  1  memory data valid this cycle
flush  in  1  abort the in-flight load (pipeline/exception flush)
out  out  DATA_W  extended load result
valid  out  1  out holds a completed load result
busy  out  1  high in WAIT
err  out  1  sticky error; cleared by the next accepted req
err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 size too large

Behaviour:
- Reset (rst=0, async): state=IDLE, out=0, valid=0, busy=0, err=0, err_code=00, wait_cnt=0, latched attributes=0. Reset asserted mid-WAIT discards the load immediately.
- States: IDLE, WAIT, FULL.
- Request acceptance:
  - req is accepted in IDLE or FULL. req is ignored in WAIT.
  - On accept: size, sign_ext and addr_lo are latched; valid<=0; err<=0; err_code<=00; wait_cnt<=0.
- Request checks, in priority order:
  - If (1<<size)*8 > DATA_W: stay in/return to IDLE; err=1, err_code=11.
  - Else if addr_lo is not a multiple of (1<<size): stay in/return to IDLE; err=1, err_code=01.
  - Else: go to WAIT.
- WAIT, priority flush > mem_ready > timeout:
  - flush: go to IDLE; no capture, no error, valid stays 0.
  - mem_ready: capture into out; go to FULL; valid=1 from the next cycle.
  - Else if wait_cnt==TIMEOUT-1: go to IDLE; err=1, err_code=10.
  - Else: wait_cnt increments.
- Latency: mem_ready in the same cycle as the req edge is not sampled. The earliest capture is the cycle after accept, so the minimum req-to-valid latency is 2 cycles.
- Extraction:
  - Lane = mem_rdata[addr_lo*8 +: (1<<size)*8].
  - Upper bits are filled with the lane MSB if sign_ext=1, else with 0.
  - A full-width access passes data through unchanged.
- FULL: out and valid hold indefinitely. flush in FULL does not clear out; flush only affects WAIT.
- Inputs mem_rdata and mem_ready are ignored outside WAIT.
- busy equals (state==WAIT), registered.
- Boundary conditions:
  - req and flush in the same cycle in IDLE/FULL: req is accepted; flush is ignored.
  - TIMEOUT=1: abort on the first WAIT cycle without mem_ready.

Test Plan:
1. Word load, DATA_W=32: req, size=10, addr_lo=0; mem_ready 3 cycles later with 0xDEADBEEF -> out=0xDEADBEEF, valid=1. out holds for 10 cycles.
2. Byte sign/zero extension: mem_rdata=0x12F45678, size=00, addr_lo=2.
   - sign_ext=1 -> out=0xFFFFFFF4.
   - sign_ext=0 -> out=0x000000F4.
3. Half load at addr_lo=2 with mem_rdata=0x8001ABCD, sign_ext=1 -> out=0xFFFF8001. Repeat with addr_lo=1 -> err=1, err_code=01, valid=0, never busy.
4. Timeout, TIMEOUT=15: req with no mem_ready -> busy high for exactly 15 cycles, then IDLE, err_code=10. A new req clears err.
5. Flush and reset: flush asserted together with mem_ready in WAIT -> IDLE, valid=0, out unchanged. rst pulsed low mid-WAIT -> all outputs 0 asynchronously.
6. DATA_W=64, LANE_W=3: size=11, mem_rdata=0x0123456789ABCDEF -> out equal to the input. size=10, addr_lo=4, sign_ext=1 -> out=0x0000000001234567.
